pc_branch_unit: RTL and testbench

//  Program-counter register and branch-resolution stage; consumes ALU result/zero.

---
 rtl/pc_branch_unit.sv | 128 ++++++++++++
 tb/tb_pc_branch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter register and branch resolution stage.
// Picks the next PC from JALR, JAL, conditional branch or sequential flow.
// A small BOOT/RUN/TRAP FSM sends misaligned redirect targets to TRAP_VECTOR.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch/taken counters.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [2:0]  branch_type,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        taken,
  output logic        trap,
`ifdef BRANCH_STATS_EN
  output logic [31:0] branch_count,
  output logic [31:0] taken_count,
`endif
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t state;

  logic        br_cond;
  logic        br_taken;
  logic        redirect;
  logic [31:0] target;
  logic        misaligned;
  logic        advance;

  assign pc_plus4 = pc + 32'd4;

  // Condition from funct3; the undefined encodings never take the branch.
  always_comb begin
    br_cond = 1'b0;
    case (branch_type)
      3'b000:         br_cond = alu_zero;
      3'b001:         br_cond = ~alu_zero;
      3'b100, 3'b110: br_cond = alu_result[0];
      3'b101, 3'b111: br_cond = ~alu_result[0];
      default:        br_cond = 1'b0;
    endcase
  end

  assign br_taken = branch & br_cond;

  // Target priority: jalr > jump > taken branch. Sequential flow is not a redirect.
  always_comb begin
    target   = pc + imm;
    redirect = 1'b0;
    if (jalr) begin
      target   = {alu_result[31:1], 1'b0};
      redirect = 1'b1;
    end else if (jump || br_taken) begin
      target   = pc + imm;
      redirect = 1'b1;
    end
  end

  assign misaligned = redirect & target[1];
  assign advance    = (state == RUN) & ~stall;

  // PC register, FSM and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= BOOT;
      instr_valid <= 1'b0;
      taken       <= 1'b0;
      trap        <= 1'b0;
      bad_addr    <= 32'd0;
    end else begin
      taken <= 1'b0;
      trap  <= 1'b0;
      case (state)
        BOOT, TRAP: begin
          // The PC already holds the reset/trap vector; just start issuing.
          state       <= RUN;
          instr_valid <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (misaligned) begin
              pc          <= TRAP_VECTOR;
              bad_addr    <= target;
              trap        <= 1'b1;
              state       <= TRAP;
              instr_valid <= 1'b0;
            end else if (redirect) begin
              pc    <= target;
              taken <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counts of resolved conditional branches and of those taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count <= 32'd0;
      taken_count  <= 32'd0;
    end else if (advance && branch) begin
      if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (br_cond && taken_count != 32'hFFFF_FFFF) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios followed by
// randomized cycles, all compared against a behavioural reference model.
module tb_pc_branch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr, alu_zero;
  logic [2:0]  branch_type;
  logic [31:0] imm, alu_result;
  logic [31:0] pc, pc_plus4, bad_addr;
  logic        instr_valid, taken, trap;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count, taken_count;
`endif

  always #5 clk = ~clk;

  pc_branch_unit #(.RESET_PC(RPC), .TRAP_VECTOR(TVEC)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_type(branch_type), .jump(jump), .jalr(jalr), .imm(imm),
    .alu_result(alu_result), .alu_zero(alu_zero), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .taken(taken), .trap(trap),
`ifdef BRANCH_STATS_EN
    .branch_count(branch_count), .taken_count(taken_count),
`endif
    .bad_addr(bad_addr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 = booting, 1 = issuing, 2 = recovering from trap.
  int          m_mode;
  logic [31:0] m_pc, m_bad;
  bit          m_iv, m_tk, m_tr;
  longint      m_bc, m_tc;

  function automatic bit cond_ok(input logic [2:0] f, input logic z, input logic [31:0] r);
    bit lt = (r % 2) == 1;
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    longint t;
    bit     redir;
    if (reset) begin
      m_pc = RPC; m_mode = 0; m_iv = 0; m_tk = 0; m_tr = 0; m_bad = 0;
      m_bc = 0; m_tc = 0;
      return;
    end
    m_tk = 0; m_tr = 0;
    if (m_mode != 1) begin
      m_mode = 1; m_iv = 1;
      return;
    end
    if (stall) return;
    if (branch) begin
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (cond_ok(branch_type, alu_zero, alu_result) && m_tc < 64'hFFFF_FFFF) m_tc++;
    end
    redir = 1;
    if (jalr) t = alu_result - (alu_result % 2);
    else if (jump || (branch && cond_ok(branch_type, alu_zero, alu_result)))
      t = (longint'(m_pc) + longint'(imm)) % 64'h1_0000_0000;
    else begin
      redir = 0;
      t = (longint'(m_pc) + 4) % 64'h1_0000_0000;
    end
    if (redir && ((t / 2) % 2) == 1) begin
      m_pc = TVEC; m_bad = t[31:0]; m_tr = 1; m_mode = 2; m_iv = 0;
    end else begin
      m_pc = t[31:0]; m_tk = redir;
    end
  endtask

  // One clock: advance the model with the applied inputs and compare everything.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
    chk("taken", {31'd0, taken}, {31'd0, m_tk});
    chk("trap", {31'd0, trap}, {31'd0, m_tr});
    chk("bad_addr", bad_addr, m_bad);
`ifdef BRANCH_STATS_EN
    chk("branch_count", branch_count, m_bc[31:0]);
    chk("taken_count", taken_count, m_tc[31:0]);
`endif
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch = 0; jump = 0; jalr = 0;
    branch_type = 3'd0; imm = 0; alu_result = 0; alu_zero = 0;
  endtask

  task automatic do_jalr(input logic [31:0] a);
    idle(); jalr = 1; alu_result = a; step();
  endtask

  task automatic do_br(input logic [2:0] f, input logic z, input logic [31:0] r,
                       input logic [31:0] im);
    idle(); branch = 1; branch_type = f; alu_zero = z; alu_result = r; imm = im; step();
  endtask

  initial begin
    idle();
    // T1: reset for two cycles, boot cycle, then sequential fetch.
    reset = 1; step(); step();
    chk("t1_rst_pc", pc, 32'h0);
    chk("t1_rst_iv", {31'd0, instr_valid}, 32'd0);
    idle(); step();
    chk("t1_boot_pc", pc, 32'h0);
    chk("t1_boot_iv", {31'd0, instr_valid}, 32'd1);
    step(); chk("t1_pc4", pc, 32'h4);
    step(); chk("t1_pc8", pc, 32'h8);
    // T2: BEQ taken and not taken from pc=8.
    do_br(3'b000, 1'b1, 32'h0, 32'h10);
    chk("t2_beq_t", pc, 32'h18); chk("t2_taken", {31'd0, taken}, 32'd1);
    do_jalr(32'h8);
    do_br(3'b000, 1'b0, 32'h5, 32'h10);
    chk("t2_beq_nt", pc, 32'hC); chk("t2_ntaken", {31'd0, taken}, 32'd0);
    // T3: BLT taken backward, BGE with the same inputs falls through.
    do_jalr(32'h20);
    do_br(3'b100, 1'b0, 32'h1, 32'hFFFF_FFF8);
    chk("t3_blt", pc, 32'h18);
    do_jalr(32'h20);
    do_br(3'b101, 1'b0, 32'h1, 32'hFFFF_FFF8);
    chk("t3_bge", pc, 32'h24);
    // T4: JALR clears bit 0; bit 1 set traps.
    do_jalr(32'h101);
    chk("t4_jalr", pc, 32'h100);
    do_jalr(32'h106);
    chk("t4_trap_pc", pc, TVEC); chk("t4_trap", {31'd0, trap}, 32'd1);
    chk("t4_bad", bad_addr, 32'h106); chk("t4_iv0", {31'd0, instr_valid}, 32'd0);
    idle(); step();
    chk("t4_hold", pc, TVEC); chk("t4_iv1", {31'd0, instr_valid}, 32'd1);
    // T5: stalled jump holds, then goes; reset during stall wins.
    idle(); jump = 1; imm = 32'h20; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_stall_pc", pc, TVEC);
    end
    stall = 0; step();
    chk("t5_jump", pc, TVEC + 32'h20);
    stall = 1; reset = 1; step();
    chk("t5_rst_stall", pc, RPC);
    idle(); step();
    // T6: wrap past the top of the address space; three branches, two taken.
    do_jalr(32'hFFFF_FFFC);
    idle(); step();
    chk("t6_wrap", pc, 32'h0);
    reset = 1; step(); idle(); step();
    do_br(3'b000, 1'b1, 32'h0, 32'h8);
    do_br(3'b001, 1'b1, 32'h0, 32'h8);
    do_br(3'b110, 1'b0, 32'h1, 32'h8);
`ifdef BRANCH_STATS_EN
    chk("t6_bcnt", branch_count, 32'd3);
    chk("t6_tcnt", taken_count, 32'd2);
`endif
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      idle();
      reset       = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 20);
      branch      = ($urandom_range(0, 99) < 40);
      jump        = ($urandom_range(0, 99) < 10);
      jalr        = ($urandom_range(0, 99) < 10);
      branch_type = 3'($urandom_range(0, 7));
      alu_zero    = 1'($urandom_range(0, 1));
      alu_result  = $urandom();
      imm         = ($urandom_range(0, 99) < 80) ? ($urandom() & 32'hFFFF_FFFC)
                                                 : ($urandom() & 32'hFFFF_FFFE);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
